// File: rtl/drawing_priority_mux.sv
// -----------------------------------------------------------------------------
// drawing_priority_mux
//
// Layer compositor for the VGA pixel path. Each pixel selects the
// lowest-indexed layer that is visible. A layer is visible when it is
// drawing, enabled, not blanked by blink and not colour-keyed. If no layer
// is visible, the background is used. The selected colour passes through a
// 2-stage pipeline.
//
// The block also gathers collisions between layer 0 (snake head) and every
// other layer over a frame. It latches that collision set at the next
// startOfFrame.
//
// Ports:
//   clk, resetN          pixel clock, asynchronous active-low reset
//   RGB_layers           NUM_LAYERS packed colours, layer i at [i*COLOR_W +: COLOR_W]
//   draw                 per-layer draw request for the current pixel
//   RGB_bg               background colour (never keyed)
//   layer_en             static per-layer enable
//   blink_mask           per-layer blink select
//   startOfFrame         one-cycle pulse at the first pixel of a frame
//   Red/Green/Blue_level colour output, 2 clocks after the inputs
//   draw_valid           output pixel came from a layer (aligned with colour)
//   collision_out        collision flags of the previous frame (bit 0 always 0)
//   collision_pulse      one-cycle strobe after a nonzero latch
// -----------------------------------------------------------------------------
module drawing_priority_mux #(
  parameter int                 NUM_LAYERS   = 4,
  parameter int                 COLOR_W      = 12,
  parameter int                 BLINK_FRAMES = 16,
  parameter bit                 TRANSP_EN    = 1'b1,
  parameter logic [COLOR_W-1:0] TRANSP_KEY   = 12'hFFF
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [NUM_LAYERS*COLOR_W-1:0] RGB_layers,
  input  logic [NUM_LAYERS-1:0]         draw,
  input  logic [COLOR_W-1:0]            RGB_bg,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic [NUM_LAYERS-1:0]         blink_mask,
  input  logic                          startOfFrame,
  output logic [COLOR_W/3-1:0]          Red_level,
  output logic [COLOR_W/3-1:0]          Green_level,
  output logic [COLOR_W/3-1:0]          Blue_level,
  output logic                          draw_valid,
  output logic [NUM_LAYERS-1:0]         collision_out,
  output logic                          collision_pulse
);

  localparam int                 CH_W    = COLOR_W / 3;
  localparam int                 FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0]    FC_LAST = FC_W'(BLINK_FRAMES - 1);
  localparam logic [COLOR_W-1:0] WHITE   = '1;

  // Per-pixel visibility and collision terms
  logic [NUM_LAYERS-1:0] eff;
  logic [NUM_LAYERS-1:0] hit;
  logic [COLOR_W-1:0]    layer_rgb;
  logic [COLOR_W-1:0]    sel_color;
  logic                  sel_valid;

  // Pipeline stages
  logic [COLOR_W-1:0] s1_color_d, s1_color_q;
  logic               s1_valid_d, s1_valid_q;
  logic [COLOR_W-1:0] out_color_d, out_color_q;
  logic               out_valid_d, out_valid_q;

  // Blink state
  logic [FC_W-1:0] frame_cnt_d, frame_cnt_q;
  logic            blink_phase_d, blink_phase_q;

  // Collision state
  logic [NUM_LAYERS-1:0] acc_d, acc_q;
  logic [NUM_LAYERS-1:0] coll_d, coll_q;
  logic                  pulse_d, pulse_q;

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    eff       = '0;
    hit       = '0;
    layer_rgb = '0;
    sel_color = RGB_bg;
    sel_valid = 1'b0;

    for (int i = 0; i < NUM_LAYERS; i++) begin
      layer_rgb = RGB_layers[i*COLOR_W +: COLOR_W];
      eff[i]    = draw[i] && layer_en[i]
                  && !(blink_mask[i] && blink_phase_q)
                  && !(TRANSP_EN && (layer_rgb == TRANSP_KEY));
    end

    // Scan from the lowest priority upwards, so the lowest visible index
    // is the last one written and wins.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff[i]) begin
        sel_color = RGB_layers[i*COLOR_W +: COLOR_W];
        sel_valid = 1'b1;
      end
    end

    for (int i = 1; i < NUM_LAYERS; i++) begin
      hit[i] = eff[0] && eff[i];
    end
  end

  always_comb begin
    s1_color_d    = sel_color;
    s1_valid_d    = sel_valid;
    out_color_d   = s1_color_q;
    out_valid_d   = s1_valid_q;

    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    acc_d         = acc_q | hit;
    coll_d        = coll_q;
    pulse_d       = 1'b0;

    if (startOfFrame) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        frame_cnt_d   = frame_cnt_q + 1'b1;
      end
      // The hits of the startOfFrame cycle itself still belong to the
      // frame that is closing.
      coll_d  = acc_q | hit;
      acc_d   = '0;
      pulse_d = |(acc_q | hit);
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop
  // samples the values from before the edge, whatever order they are listed in.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_color_q    <= WHITE;
      s1_valid_q    <= 1'b0;
      out_color_q   <= WHITE;
      out_valid_q   <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      acc_q         <= '0;
      coll_q        <= '0;
      pulse_q       <= 1'b0;
    end else begin
      s1_color_q    <= s1_color_d;
      s1_valid_q    <= s1_valid_d;
      out_color_q   <= out_color_d;
      out_valid_q   <= out_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      acc_q         <= acc_d;
      coll_q        <= coll_d;
      pulse_q       <= pulse_d;
    end
  end

  assign Red_level       = out_color_q[COLOR_W-1 -: CH_W];
  assign Green_level     = out_color_q[2*CH_W-1 -: CH_W];
  assign Blue_level      = out_color_q[CH_W-1:0];
  assign draw_valid      = out_valid_q;
  assign collision_out   = coll_q;
  assign collision_pulse = pulse_q;

endmodule

// File: tb/tb_drawing_priority_mux.sv
// -----------------------------------------------------------------------------
// tb_drawing_priority_mux
//
// Bench for drawing_priority_mux with 4 layers, 12-bit colour, a blink
// half-period of 2 frames and key 12'hFFF.
//
// A reference model follows the compositing rules: visibility per layer,
// lowest visible index wins, and the blink phase comes from the number of
// frames seen since reset. The model feeds a 2-deep expectation pipe and a
// collision accumulator, and it is compared with the DUT on every falling
// edge. Directed sequences add literal expected values at the key points.
// -----------------------------------------------------------------------------
module tb_drawing_priority_mux;

  localparam int NL = 4;
  localparam int CW = 12;
  localparam int BF = 2;
  localparam logic [CW-1:0] KEY = 12'hFFF;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NL*CW-1:0] rgb_layers;
  logic [NL-1:0]  draw;
  logic [CW-1:0]  rgb_bg;
  logic [NL-1:0]  layer_en;
  logic [NL-1:0]  blink_mask;
  logic           sof;
  logic [3:0]     red, green, blue;
  logic           draw_valid;
  logic [NL-1:0]  coll;
  logic           pulse;

  int checks = 0;
  int errors = 0;

  drawing_priority_mux #(
    .NUM_LAYERS  (NL),
    .COLOR_W     (CW),
    .BLINK_FRAMES(BF),
    .TRANSP_EN   (1'b1),
    .TRANSP_KEY  (KEY)
  ) dut (
    .clk            (clk),
    .resetN         (rst_n),
    .RGB_layers     (rgb_layers),
    .draw           (draw),
    .RGB_bg         (rgb_bg),
    .layer_en       (layer_en),
    .blink_mask     (blink_mask),
    .startOfFrame   (sof),
    .Red_level      (red),
    .Green_level    (green),
    .Blue_level     (blue),
    .draw_valid     (draw_valid),
    .collision_out  (coll),
    .collision_pulse(pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [NL-1:0] visible(input logic [NL-1:0] d, input logic [NL-1:0] en,
                                            input logic [NL-1:0] mk, input logic [NL*CW-1:0] lay,
                                            input logic ph);
    logic [NL-1:0] v;
    v = '0;
    for (int i = 0; i < NL; i++)
      v[i] = d[i] && en[i] && !(mk[i] && ph) && (lay[i*CW +: CW] != KEY);
    return v;
  endfunction

  // {valid, colour}: first visible layer by ascending index, else background
  function automatic logic [CW:0] pick(input logic [NL-1:0] v, input logic [NL*CW-1:0] lay,
                                       input logic [CW-1:0] bg);
    for (int i = 0; i < NL; i++)
      if (v[i]) return {1'b1, lay[i*CW +: CW]};
    return {1'b0, bg};
  endfunction

  function automatic logic [NL-1:0] hits(input logic [NL-1:0] v);
    return v[0] ? {v[NL-1:1], 1'b0} : '0;
  endfunction

  function automatic logic phase_of(input int frames);
    return ((frames / BF) % 2) == 1;
  endfunction

  logic [CW:0]   m_s1 = {1'b0, 12'hFFF};
  logic [CW:0]   m_s2 = {1'b0, 12'hFFF};
  logic [NL-1:0] m_acc = '0;
  logic [NL-1:0] m_coll = '0;
  logic          m_pulse = 1'b0;
  int            m_frames = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1     <= {1'b0, 12'hFFF};
      m_s2     <= {1'b0, 12'hFFF};
      m_acc    <= '0;
      m_coll   <= '0;
      m_pulse  <= 1'b0;
      m_frames <= 0;
    end else begin
      m_s2 <= m_s1;
      m_s1 <= pick(visible(draw, layer_en, blink_mask, rgb_layers, phase_of(m_frames)),
                   rgb_layers, rgb_bg);
      if (sof) begin
        m_coll   <= m_acc | hits(visible(draw, layer_en, blink_mask, rgb_layers, phase_of(m_frames)));
        m_pulse  <= |(m_acc | hits(visible(draw, layer_en, blink_mask, rgb_layers, phase_of(m_frames))));
        m_acc    <= '0;
        m_frames <= m_frames + 1;
      end else begin
        m_acc    <= m_acc | hits(visible(draw, layer_en, blink_mask, rgb_layers, phase_of(m_frames)));
        m_pulse  <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("model_pixel", {draw_valid, red, green, blue}, m_s2);
    check("model_coll", {pulse, coll}, {m_pulse, m_coll});
  end

  // ---------------- directed stimulus ----------------
  task automatic set_layers(input logic [CW-1:0] l0, l1, l2, l3);
    rgb_layers = {l3, l2, l1, l0};
  endtask

  task automatic expect_pix(input string name, input logic [CW-1:0] rgb, input logic v);
    check(name, {draw_valid, red, green, blue}, {v, rgb});
  endtask

  // startOfFrame for one cycle; returns on the falling edge right after the latch
  task automatic pulse_sof();
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask

  logic [5:0] blink_red;

  initial begin
    rst_n = 1'b0; draw = '0; rgb_bg = '0; layer_en = '1; blink_mask = '0; sof = 1'b0;
    set_layers(12'h000, 12'h000, 12'h000, 12'h000);

    @(negedge clk);
    expect_pix("reset_pixel", 12'hFFF, 1'b0);
    check("reset_coll", {pulse, coll}, 5'h00);
    rst_n = 1'b1;

    // Priority: layer 1 beats layer 2
    set_layers(12'h000, 12'h0F0, 12'hF00, 12'h000);
    draw = 4'b0110;
    repeat (2) @(negedge clk);
    expect_pix("prio_l1", 12'h0F0, 1'b1);
    draw = 4'b0000; rgb_bg = 12'h123;
    repeat (2) @(negedge clk);
    expect_pix("prio_bg", 12'h123, 1'b0);

    // Enable and transparency
    set_layers(12'h0AA, 12'h00F, 12'h000, 12'h000);
    draw = 4'b0011; layer_en = 4'b1110;
    repeat (2) @(negedge clk);
    expect_pix("en_l0_off", 12'h00F, 1'b1);
    set_layers(12'h0AA, 12'hFFF, 12'h000, 12'h000);
    repeat (2) @(negedge clk);
    expect_pix("key_fallthru", 12'h123, 1'b0);
    draw = 4'b0000; rgb_bg = 12'hFFF;
    repeat (2) @(negedge clk);
    expect_pix("bg_not_keyed", 12'hFFF, 1'b0);
    layer_en = '1; rgb_bg = 12'h123;

    // Blink, starting from a fresh phase
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    blink_mask = 4'b0001; draw = 4'b0001;
    set_layers(12'hF00, 12'h000, 12'h000, 12'h000);
    blink_red = 6'b110011;   // frame index -> layer visible (bit f)
    for (int f = 0; f < 6; f++) begin
      repeat (3) @(negedge clk);
      expect_pix($sformatf("blink_f%0d", f), blink_red[f] ? 12'hF00 : 12'h123, blink_red[f]);
      pulse_sof();
    end
    blink_mask = '0; draw = '0;

    // Collision layer 0 vs layer 2 mid-frame
    set_layers(12'hF00, 12'h0AA, 12'h00F, 12'h0F0);
    pulse_sof();
    draw = 4'b0101;
    @(negedge clk);
    draw = 4'b0000;
    repeat (2) @(negedge clk);
    pulse_sof();
    check("coll_latch", coll, 4'b0100);
    check("coll_pulse", pulse, 1'b1);
    @(negedge clk);
    check("coll_pulse_1cyc", pulse, 1'b0);
    check("coll_held", coll, 4'b0100);
    repeat (3) @(negedge clk);
    pulse_sof();
    check("coll_clear", {pulse, coll}, 5'h00);

    // Hit on layer 3 within the startOfFrame cycle
    draw = 4'b1001;
    pulse_sof();
    draw = 4'b0000;
    check("simul_latch", {pulse, coll}, 5'h18);
    repeat (2) @(negedge clk);
    pulse_sof();
    check("simul_acc_zero", {pulse, coll}, 5'h00);

    // Back-to-back startOfFrame: the second latches only its own cycle
    draw = 4'b0011;
    @(negedge clk);
    draw = 4'b0000;
    sof = 1'b1;
    @(negedge clk);
    check("b2b_first", {pulse, coll}, 5'h12);
    @(negedge clk);
    sof = 1'b0;
    check("b2b_second", {pulse, coll}, 5'h00);

    // Asynchronous reset mid-frame with pending hits
    draw = 4'b0101;
    @(negedge clk);
    pulse_sof();
    check("pre_reset_coll", coll, 4'b0100);
    repeat (2) @(negedge clk);
    expect_pix("pre_reset_pix", 12'hF00, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    expect_pix("reset_async_pix", 12'hFFF, 1'b0);
    check("reset_async_coll", {pulse, coll}, 5'h00);
    @(negedge clk);
    rst_n = 1'b1;
    draw = 4'b0000;
    repeat (3) @(negedge clk);
    pulse_sof();
    check("post_reset_latch", {pulse, coll}, 5'h00);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
